song_sequencer: RTL and testbench

- Parametrised multi-voice song player; successor to the fixed two-voice hard-coded melody block.
- Song events are read from an external synchronous ROM, so the melody is data rather than logic.
- Note codes map to wave-generator divisors. Drives VOICES wave instances, one div and one gate per voice.
- Adds an internal tempo prescaler, start/stop/loop control, end-of-song detection, and a note-articulation gap so repeated notes are audible as separate notes.

---
 rtl/song_pkg.sv | 66 ++++++
 rtl/song_sequencer_note_lut.sv | 17 +
 rtl/song_sequencer.sv | 149 ++++++++++++++
 tb/tb_song_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared note codes, divisor table and sequencer state type for the song player.
package song_pkg;

  localparam int unsigned REST = 0;
  localparam int unsigned L6   = 1;
  localparam int unsigned L7   = 2;
  localparam int unsigned M1   = 3;
  localparam int unsigned M2   = 4;
  localparam int unsigned M3   = 5;
  localparam int unsigned M4   = 6;
  localparam int unsigned M5   = 7;
  localparam int unsigned M6   = 8;
  localparam int unsigned M7   = 9;
  localparam int unsigned H1   = 10;
  localparam int unsigned H2   = 11;
  localparam int unsigned H3   = 12;
  localparam int unsigned H4   = 13;
  localparam int unsigned H5   = 14;
  localparam int unsigned H6   = 15;
  localparam int unsigned H7   = 16;

  // Wave-generator divisors for a 2.08 MHz clock (clk / note frequency).
  localparam int unsigned DIV_L6 = 9455;
  localparam int unsigned DIV_L7 = 8423;
  localparam int unsigned DIV_M1 = 7950;
  localparam int unsigned DIV_M2 = 7083;
  localparam int unsigned DIV_M3 = 6310;
  localparam int unsigned DIV_M4 = 5956;
  localparam int unsigned DIV_M5 = 5306;
  localparam int unsigned DIV_M6 = 4727;
  localparam int unsigned DIV_M7 = 4212;
  localparam int unsigned DIV_H1 = 3975;
  localparam int unsigned DIV_H2 = 3542;
  localparam int unsigned DIV_H3 = 3155;
  localparam int unsigned DIV_H4 = 2978;
  localparam int unsigned DIV_H5 = 2653;
  localparam int unsigned DIV_H6 = 2364;
  localparam int unsigned DIV_H7 = 2106;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  // Unknown codes return 0, which the caller treats as a rest.
  function automatic logic [31:0] note_divisor(input logic [31:0] code);
    case (code)
      REST:    note_divisor = '0;
      L6:      note_divisor = DIV_L6;
      L7:      note_divisor = DIV_L7;
      M1:      note_divisor = DIV_M1;
      M2:      note_divisor = DIV_M2;
      M3:      note_divisor = DIV_M3;
      M4:      note_divisor = DIV_M4;
      M5:      note_divisor = DIV_M5;
      M6:      note_divisor = DIV_M6;
      M7:      note_divisor = DIV_M7;
      H1:      note_divisor = DIV_H1;
      H2:      note_divisor = DIV_H2;
      H3:      note_divisor = DIV_H3;
      H4:      note_divisor = DIV_H4;
      H5:      note_divisor = DIV_H5;
      H6:      note_divisor = DIV_H6;
      H7:      note_divisor = DIV_H7;
      default: note_divisor = '0;
    endcase
  endfunction

endpackage

// File: rtl/song_sequencer_note_lut.sv
// Combinational note-code to wave divisor lookup; valid is low for rests and unknown codes.
module note_lut #(
  parameter int unsigned NOTE_W = 5,
  parameter int unsigned DIV_W  = 17
) (
  input  logic [NOTE_W-1:0] code,
  output logic [DIV_W-1:0]  div,
  output logic              valid
);
  import song_pkg::*;

  always_comb begin
    div   = DIV_W'(note_divisor(32'(code)));
    valid = (div != '0);
  end

endmodule

// File: rtl/song_sequencer.sv
// Multi-voice song player: fetches events from a sync ROM, drives per-voice divisors and gates
// at a prescaled tempo, with loop/stop control and an articulation gap at the end of each note.
module song_sequencer #(
  parameter int unsigned VOICES         = 2,
  parameter int unsigned NOTE_W         = 5,
  parameter int unsigned DIV_W          = 17,
  parameter int unsigned DUR_W          = 3,
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned TEMPO_DIV      = 65000,
  parameter int unsigned TICKS_PER_UNIT = 8,
  parameter int unsigned GAP_TICKS      = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            loop,
  output logic [ADDR_W-1:0]               rom_addr,
  input  logic [DUR_W+VOICES*NOTE_W-1:0]  rom_data,
  output logic [VOICES*DIV_W-1:0]         div,
  output logic [VOICES-1:0]               gate,
  output logic                            busy,
  output logic                            done
);
  import song_pkg::*;

  localparam int unsigned EVT_W = DUR_W + VOICES * NOTE_W;
  localparam int unsigned REM_W = DUR_W + $clog2(TICKS_PER_UNIT) + 1;
  localparam int unsigned PRE_W = (TEMPO_DIV > 1) ? $clog2(TEMPO_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TEMPO_DIV - 1);
  localparam logic [REM_W-1:0] GAP_R    = REM_W'(GAP_TICKS);
  localparam logic             GAP_EN   = (GAP_TICKS != 0);

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         ptr_q, ptr_d;
  logic [REM_W-1:0]          rem_q, rem_d;
  logic [PRE_W-1:0]          pre_q;
  logic [VOICES*DIV_W-1:0]   div_q, div_d;
  logic [VOICES-1:0]         gate_q, gate_d;
  logic                      done_q, done_d;
  logic [VOICES*DIV_W-1:0]   lut_div;
  logic [VOICES-1:0]         lut_valid;
  logic [DUR_W-1:0]          dur;
  logic                      active, tick, accept, gap;

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    note_lut #(
      .NOTE_W (NOTE_W),
      .DIV_W  (DIV_W)
    ) u_lut (
      .code  (rom_data[v*NOTE_W +: NOTE_W]),
      .div   (lut_div[v*DIV_W +: DIV_W]),
      .valid (lut_valid[v])
    );
  end

  assign dur    = rom_data[EVT_W-1 -: DUR_W];
  assign active = (state_q != IDLE);
  assign tick   = active && (pre_q == PRE_LAST);
  assign accept = (state_q == IDLE) && start && !stop;
  assign gap    = GAP_EN && (rem_q <= GAP_R);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else if (accept || tick) begin
      pre_q <= '0;
    end else if (active) begin
      pre_q <= pre_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    div_d   = div_q;
    gate_d  = gate_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = FETCH;
          ptr_d   = '0;
          rem_d   = '0;
          div_d   = '0;
          gate_d  = '0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        if (dur == '0) begin
          if (loop) begin
            ptr_d   = '0;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          div_d   = lut_div;
          gate_d  = lut_valid;
          rem_d   = REM_W'(dur) * REM_W'(TICKS_PER_UNIT);
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == REM_W'(1)) begin
            ptr_d   = ptr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop && active) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      gate_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
    end
  end

  // Held note registers are masked rather than cleared so stop/end zero the outputs on the same cycle.
  assign rom_addr = ptr_q;
  assign div      = active ? div_q : '0;
  assign gate     = (active && !gap) ? gate_q : '0;
  assign busy     = active;
  assign done     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: event-level reference model compared every cycle, directed scenarios
// with hand-computed timing, and randomized ROM contents and control.
module tb_song_sequencer;

  localparam int unsigned VOICES    = 2;
  localparam int unsigned NOTE_W    = 5;
  localparam int unsigned DIV_W     = 17;
  localparam int unsigned DUR_W     = 3;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned TEMPO_DIV = 4;
  localparam int unsigned TPU       = 2;
  localparam int unsigned GAP       = 1;
  localparam int unsigned EVT_W     = DUR_W + VOICES * NOTE_W;
  localparam int unsigned DEPTH     = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic stop  = 1'b0;
  logic loop  = 1'b0;
  logic [ADDR_W-1:0]        rom_addr;
  logic [EVT_W-1:0]         rom_data;
  logic [VOICES*DIV_W-1:0]  div;
  logic [VOICES-1:0]        gate;
  logic                     busy, done;

  logic [EVT_W-1:0] rom [DEPTH];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  int unsigned ref_tbl [17] = '{0, 9455, 8423, 7950, 7083, 6310, 5956, 5306, 4727,
                                4212, 3975, 3542, 3155, 2978, 2653, 2364, 2106};

  always #5 clk = ~clk;

  song_sequencer #(
    .VOICES         (VOICES),
    .NOTE_W         (NOTE_W),
    .DIV_W          (DIV_W),
    .DUR_W          (DUR_W),
    .ADDR_W         (ADDR_W),
    .TEMPO_DIV      (TEMPO_DIV),
    .TICKS_PER_UNIT (TPU),
    .GAP_TICKS      (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .div      (div),
    .gate     (gate),
    .busy     (busy),
    .done     (done)
  );

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned ref_div(input int unsigned code);
    return (code < 17) ? ref_tbl[code] : 0;
  endfunction

  function automatic int unsigned dv(input int v);
    return int'(div[v*DIV_W +: DIV_W]);
  endfunction

  function automatic logic [EVT_W-1:0] ev(input int unsigned d, input int unsigned n1,
                                          input int unsigned n0);
    return {DUR_W'(d), NOTE_W'(n1), NOTE_W'(n0)};
  endfunction

  // Reference model: a song is a list of events; each note holds for dur*TPU tempo ticks,
  // each event costs two clocks of fetch before it sounds.
  bit               m_busy = 0, m_done = 0, m_tk;
  bit [ADDR_W-1:0]  m_addr = '0;
  int               m_step = 0, m_left = 0, m_cyc = 0, m_d;
  int unsigned      m_code [VOICES];
  logic [EVT_W-1:0] m_w;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_addr = '0; m_step = 0; m_left = 0; m_cyc = 0;
      foreach (m_code[v]) m_code[v] = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start && !stop) begin
          m_busy = 1; m_addr = '0; m_step = 0; m_left = 0; m_cyc = 0;
          foreach (m_code[v]) m_code[v] = 0;
        end
      end else if (stop) begin
        m_busy = 0;
      end else begin
        m_tk = (m_cyc % TEMPO_DIV) == (TEMPO_DIV - 1);
        m_cyc++;
        if (m_step == 0) begin
          m_step = 1;
        end else if (m_step == 1) begin
          m_w = rom[m_addr];
          m_d = int'(m_w[EVT_W-1 -: DUR_W]);
          if (m_d == 0) begin
            if (loop) begin m_addr = '0; m_step = 0; end
            else begin m_busy = 0; m_done = 1; end
          end else begin
            for (int v = 0; v < VOICES; v++) m_code[v] = int'(m_w[v*NOTE_W +: NOTE_W]);
            m_left = m_d * TPU;
            m_step = 2;
          end
        end else if (m_tk) begin
          m_left--;
          if (m_left == 0) begin m_addr = m_addr + 1'b1; m_step = 0; end
        end
      end
    end
  end

  function automatic bit exp_gate(input int v);
    return m_busy && (ref_div(m_code[v]) != 0) && !(GAP > 0 && m_left <= GAP);
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_en && !rst) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (m_busy) chk("rom_addr", rom_addr, m_addr);
      for (int v = 0; v < VOICES; v++) begin
        chk($sformatf("div%0d", v), dv(v), m_busy ? ref_div(m_code[v]) : 0);
        chk($sformatf("gate%0d", v), gate[v], exp_gate(v));
      end
    end
  end

  task automatic clear_rom();
    for (int a = 0; a < DEPTH; a++) rom[a] = '0;
  endtask

  task automatic load_song1();
    clear_rom();
    rom[0] = ev(1, 5, 8);
    rom[1] = ev(2, 0, 10);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    chk(name, done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, dones, g0hi, done_k, mdone_k, n, rises, fall1, rise2, busy_lo;
    bit g [64];
    int seq [$];
    logic [ADDR_W-1:0] prev_a;

    clear_rom();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div", div, 0);
    chk("rst_gate", gate, 0);
    chk("rst_addr", rom_addr, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Basic play
    load_song1();
    pulse_start();
    k = 1; dones = 0; g0hi = 0; done_k = 0; mdone_k = 0;
    while (k <= 40) begin
      if (k == 3) begin
        chk("s1_div0_m6", dv(0), 4727);
        chk("s1_div1_m3", dv(1), 6310);
        chk("s1_gate0_on", gate[0], 1);
      end
      if (k == 5) chk("s1_gate0_gap", gate[0], 0);
      if (k == 11) begin
        chk("s1_div0_h1", dv(0), 3975);
        chk("s1_gate0_h1", gate[0], 1);
        chk("s1_gate1_rest", gate[1], 0);
      end
      if (gate[0]) g0hi++;
      if (done) begin
        dones++;
        if (done_k == 0) done_k = k;
        chk("s1_busy_at_done", busy, 0);
      end
      if (m_done && mdone_k == 0) mdone_k = k;
      @(negedge clk);
      k++;
    end
    chk("s1_done_cycle", done_k, 27);
    chk("s1_model_done_cycle", mdone_k, 27);
    chk("s1_done_pulses", dones, 1);
    chk("s1_gate0_cycles", g0hi, 12);

    // Repeated note
    clear_rom();
    rom[0] = ev(1, 8, 8);
    rom[1] = ev(1, 8, 8);
    pulse_start();
    done_k = 0;
    for (int i = 0; i < 64; i++) g[i] = 0;
    for (k = 1; k <= 30; k++) begin
      g[k] = gate[0];
      if (k >= 3 && k <= 18) chk("s2_div_hold", dv(0), 4727);
      if (done && done_k == 0) done_k = k;
      @(negedge clk);
    end
    rises = 0; fall1 = 0; rise2 = 0;
    for (int i = 2; i <= 30; i++) begin
      if (g[i] && !g[i-1]) begin rises++; if (rises == 2) rise2 = i; end
      if (!g[i] && g[i-1] && fall1 == 0) fall1 = i;
    end
    chk("s2_rises", rises, 2);
    chk("s2_gap_clk", rise2 - fall1, 6);
    chk("s2_done_cycle", done_k, 19);

    // Loop
    load_song1();
    loop = 1'b1;
    pulse_start();
    dones = 0; busy_lo = 0;
    for (k = 1; k <= 80; k++) begin
      if (k == 27) chk("s3_addr_wrap", rom_addr, 0);
      if (k == 29) begin
        chk("s3_replay_m6", dv(0), 4727);
        chk("s3_replay_gate", gate[0], 1);
      end
      if (done) dones++;
      if (!busy) busy_lo++;
      @(negedge clk);
    end
    chk("s3_no_done", dones, 0);
    chk("s3_busy_held", busy_lo, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop = 1'b0;
    chk("s3_stop_busy", busy, 0);

    // Stop mid-note
    repeat (2) @(negedge clk);
    pulse_start();
    n = 0;
    while (dv(0) != 3975 && n < 40) begin @(negedge clk); n++; end
    chk("s4_reach_h1", dv(0), 3975);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("s4_div_zero", div, 0);
    chk("s4_gate_zero", gate, 0);
    chk("s4_busy_zero", busy, 0);
    chk("s4_done_zero", done, 0);
    repeat (3) @(negedge clk);
    pulse_start();
    chk("s4_restart_addr", rom_addr, 0);
    chk("s4_restart_busy", busy, 1);
    repeat (2) @(negedge clk);
    chk("s4_restart_m6", dv(0), 4727);
    wait_done(60, "s4_done");

    // Asynchronous reset mid-song
    @(negedge clk);
    pulse_start();
    repeat (12) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("s5_div", div, 0);
    chk("s5_gate", gate, 0);
    chk("s5_busy", busy, 0);
    chk("s5_done", done, 0);
    chk("s5_addr", rom_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("s5_idle_after", busy, 0);

    // start and stop together
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("s6_startstop", busy, 0);
    repeat (4) @(negedge clk);
    chk("s6_startstop_later", busy, 0);

    // No end marker: address wraps
    for (int a = 0; a < DEPTH; a++) rom[a] = ev(1, 4, 3);
    pulse_start();
    seq.delete();
    seq.push_back(int'(rom_addr));
    prev_a = rom_addr;
    n = 0;
    while (seq.size() < DEPTH + 1 && n < 200) begin
      @(negedge clk);
      n++;
      if (rom_addr != prev_a) begin seq.push_back(int'(rom_addr)); prev_a = rom_addr; end
    end
    chk("s6_wrap_len", seq.size(), DEPTH + 1);
    for (int i = 0; i < seq.size(); i++) chk($sformatf("s6_wrap_addr%0d", i), seq[i], i % DEPTH);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // Unknown code on voice 0
    clear_rom();
    rom[0] = ev(1, 3, 31);
    @(negedge clk);
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    chk("s6_unk_div0", dv(0), 0);
    chk("s6_unk_gate0", gate[0], 0);
    chk("s6_unk_div1", dv(1), 7950);
    chk("s6_unk_gate1", gate[1], 1);
    wait_done(40, "s6_unk_done");

    // Randomized songs and control
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      for (int a = 0; a < DEPTH; a++)
        rom[a] = ev((($urandom % 5) == 0) ? 0 : $urandom_range(1, 7),
                    $urandom_range(0, 31), $urandom_range(0, 31));
      loop = 1'($urandom_range(0, 1));
      for (int c = 0; c < 300; c++) begin
        start = (($urandom % 6) == 0);
        stop  = (($urandom % 150) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      stop  = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      loop = 1'b0;
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
